// File: rtl/demux2_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux2_pkg;

  // Occupancy of one per-destination skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Destination index values carried on in_sel.
  localparam logic DEST0 = 1'b0;
  localparam logic DEST1 = 1'b1;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer holding beats for one demux destination.
// Latency: a pushed beat is visible on valid/data right after the push edge.
// Backpressure: full is a registered flag, so pop_ready never reaches the push side combinationally.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   push, push_data    - write one beat (caller guarantees no push while full)
//   full               - both entries occupied
//   pop_ready          - downstream accepts the head beat
//   valid, data        - head beat presented downstream
module skid_buf2
  import demux2_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  buf_state_t       state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign pop   = valid && pop_ready;
  assign full  = (state == FULL);
  assign valid = (state != EMPTY);
  assign data  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state <= ONE;
            head  <= push_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state <= FULL;
            tail  <= push_data;
          end else if (push && pop) begin
            // Head drains and refills on the same edge; occupancy stays at one.
            head <= push_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // No push can arrive here: the input side sees full and holds off.
          if (pop) begin
            state <= ONE;
            head  <= tail;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// 1:2 stream demultiplexer: steers each input beat to out0 or out1 by in_sel.
// Latency: an accepted beat is valid on its output right after the accepting edge.
// Backpressure: per-destination 2-entry skid buffers; in_ready = !full[in_sel], no ready-to-ready path.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   in_data, in_sel, in_valid       - input beat, its destination, its valid
//   in_ready                        - input beat accepted this cycle
//   outN_data, outN_valid, outN_ready - output stream N (N = 0, 1)
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // Ready depends only on the selected buffer's registered full flag.
  assign in_ready = (in_sel == DEST1) ? !full1 : !full0;

  assign push0 = in_valid && in_ready && (in_sel == DEST0);
  assign push1 = in_valid && in_ready && (in_sel == DEST1);

  skid_buf2 #(.WIDTH(WIDTH)) u_buf0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop_ready (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data)
  );

  skid_buf2 #(.WIDTH(WIDTH)) u_buf1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop_ready (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data)
  );

`ifndef SYNTHESIS
  // An unknown destination on a live beat would silently pick a buffer.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      assert (!$isunknown(in_sel))
        else $error("%m: in_sel is X while in_valid is high");
    end
  end
`endif

endmodule

// File: tb/tb_demux2_stream.sv
module tb_demux2_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Scoreboard: beats accepted for each destination and not yet delivered.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  demux2_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle; the expected beat goes into the scoreboard at the edge
  // where the reference model says the input handshake completes.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1, input logic rs);
    bit acc;
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    rst        = rs;
    #1;
    // A destination accepts while it holds fewer than two undelivered beats,
    // judged at the start of the cycle (a same-cycle pop does not help).
    acc = !rs && v && (s ? (q1.size() < 2) : (q0.size() < 2));
    @(posedge clk);
    if (rs) begin
      q0.delete();
      q1.delete();
    end else if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  // Monitor: compare presented outputs with the scoreboard, pop on transfer.
  always begin
    bit p0;
    bit p1;
    bit exp_rdy;
    p0 = 1'b0;
    p1 = 1'b0;
    @(negedge clk);
    #2;
    if (mon_en) begin
      exp_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
      if (in_valid) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() > 0});
      chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() > 0});
      if (q0.size() > 0) chk("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
      if (q1.size() > 0) chk("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
      p0 = !rst && out0_ready && (q0.size() > 0);
      p1 = !rst && out1_ready && (q1.size() > 0);
    end
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 1);
    mon_en = 1'b1;

    // Reset state with idle input.
    @(negedge clk);
    #3;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out0_data",  {24'd0, out0_data},  32'd0);
    chk("rst_out1_data",  {24'd0, out1_data},  32'd0);

    // Interleaved stream, both consumers ready.
    step(1, 0, 8'h01, 1, 1, 0);
    step(1, 1, 8'h02, 1, 1, 0);
    step(1, 0, 8'h03, 1, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);

    // Stall dest 0: two accepted, third waits until after the first pop.
    step(1, 0, 8'h0A, 0, 1, 0);
    step(1, 0, 8'h0B, 0, 1, 0);
    step(1, 0, 8'h0C, 0, 1, 0);
    step(1, 0, 8'h0C, 1, 1, 0);
    step(1, 0, 8'h0C, 1, 1, 0);
    repeat (3) step(0, 0, 8'h00, 1, 1, 0);

    // Dest 0 full and stalled; dest 1 still accepts.
    step(1, 0, 8'h21, 0, 0, 0);
    step(1, 0, 8'h22, 0, 0, 0);
    step(1, 1, 8'h55, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 8'h56, 0, 0, 0);

    // Both full, reset with a live beat: everything dropped.
    step(1, 0, 8'h77, 1, 1, 1);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("post_rst_q0_empty", q0.size(), 32'd0);

    // Unknown destination on an idle input is harmless.
    step(0, 1'bx, 8'hEE, 1, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 299) == 0);
    end

    // Drain.
    repeat (6) step(0, 0, 8'h00, 1, 1, 0);
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
